// File: rtl/decode_seq.sv
// decode_seq: multi-cycle instruction decoder and control sequencer for the
// mrhankey datapath. It takes one instruction at a time over a valid/ready
// handshake and walks it through fetch, decode and execute states. All
// control outputs are registered, so every strobe is glitch-free and lasts
// exactly one cycle.
module decode_seq #(
    parameter int IW   = 8,
    parameter int NREG = 4,
    parameter int CW   = 16
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [IW-1:0]                 ir,
    input  logic                          ir_valid,
    output logic                          ir_ready,
    output logic [$clog2(NREG)-1:0]       rd_sel,
    output logic [$clog2(NREG)-1:0]       rs_sel,
    output logic [IW-3-$clog2(NREG):0]    imm,
    output logic                          imm_sel,
    output logic                          alu_op,
    output logic                          alu_en,
    output logic [NREG-1:0]               load,
    output logic                          halt,
    output logic                          illegal,
    output logic [CW-1:0]                 retired
);

    localparam int RW   = $clog2(NREG);
    localparam int IMMW = IW - 2 - RW;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_SYS = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC_LDI,
        EXEC_ALU,
        WB_ALU,
        ILL,
        HALTED
    } state_t;

    state_t state;
    state_t state_next;

    logic            accept;
    logic [IW-1:0]   ir_lat;
    opcode_t         lat_op;
    logic [RW-1:0]   lat_rd;
    logic [RW-1:0]   lat_rs;
    logic [IMMW-1:0] lat_imm;
    logic            lat_is_halt;
    logic [NREG-1:0] lat_rd_onehot;

    logic [RW-1:0]   rd_sel_next;
    logic [RW-1:0]   rs_sel_next;
    logic [IMMW-1:0] imm_next;
    logic            imm_sel_next;
    logic            alu_op_next;
    logic            alu_en_next;
    logic [NREG-1:0] load_next;
    logic            halt_next;
    logic            illegal_next;
    logic [CW-1:0]   retired_next;

    // Handshake: the sequencer only takes work in FETCH, and never while
    // reset is asserted so a colliding instruction is simply not accepted.
    assign ir_ready = (state == FETCH) & ~clr;
    assign accept   = ir_valid & ir_ready;

    // Field extraction from the latched copy; the live ir bus is ignored
    // once an instruction has been taken.
    assign lat_op        = opcode_t'(ir_lat[IW-1:IW-2]);
    assign lat_rd        = ir_lat[IW-3:IW-2-RW];
    assign lat_rs        = ir_lat[IW-3-RW:IW-2-2*RW];
    assign lat_imm       = ir_lat[IW-3-RW:0];
    assign lat_is_halt   = &ir_lat;
    assign lat_rd_onehot = NREG'(1) << lat_rd;

    // Capture the instruction word at the moment of acceptance.
    always_ff @(posedge clk) begin
        if (clr) begin
            ir_lat <= '0;
        end else if (accept) begin
            ir_lat <= ir;
        end
    end

    // State register plus the registered control outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= FETCH;
            rd_sel  <= '0;
            rs_sel  <= '0;
            imm     <= '0;
            imm_sel <= 1'b0;
            alu_op  <= 1'b0;
            alu_en  <= 1'b0;
            load    <= '0;
            halt    <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state   <= state_next;
            rd_sel  <= rd_sel_next;
            rs_sel  <= rs_sel_next;
            imm     <= imm_next;
            imm_sel <= imm_sel_next;
            alu_op  <= alu_op_next;
            alu_en  <= alu_en_next;
            load    <= load_next;
            halt    <= halt_next;
            illegal <= illegal_next;
            retired <= retired_next;
        end
    end

    // Next-state logic: DECODE branches on the latched opcode, every execute
    // state returns to FETCH, and HALTED is only left through reset.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (accept) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (lat_op)
                    OP_LDI:  state_next = EXEC_LDI;
                    OP_ADD:  state_next = EXEC_ALU;
                    OP_SUB:  state_next = EXEC_ALU;
                    default: state_next = lat_is_halt ? HALTED : ILL;
                endcase
            end
            EXEC_LDI: state_next = FETCH;
            EXEC_ALU: state_next = WB_ALU;
            WB_ALU:   state_next = FETCH;
            ILL:      state_next = FETCH;
            HALTED:   state_next = HALTED;
            default:  state_next = FETCH;
        endcase
    end

    // Output logic: values for the cycle spent in state_next, so the strobes
    // line up with the state they belong to once registered.
    always_comb begin
        rd_sel_next  = rd_sel;
        rs_sel_next  = rs_sel;
        imm_next     = imm;
        alu_op_next  = alu_op;
        imm_sel_next = 1'b0;
        alu_en_next  = 1'b0;
        load_next    = '0;
        halt_next    = halt;
        illegal_next = 1'b0;
        retired_next = retired;

        if (state == DECODE) begin
            rd_sel_next = lat_rd;
            rs_sel_next = lat_rs;
            imm_next    = lat_imm;
            alu_op_next = (lat_op == OP_SUB);
        end

        case (state_next)
            EXEC_LDI: begin
                load_next    = lat_rd_onehot;
                imm_sel_next = 1'b1;
                retired_next = retired + CW'(1);
            end
            EXEC_ALU: begin
                alu_en_next = 1'b1;
            end
            WB_ALU: begin
                load_next    = lat_rd_onehot;
                retired_next = retired + CW'(1);
            end
            ILL: begin
                illegal_next = 1'b1;
            end
            HALTED: begin
                halt_next = 1'b1;
                if (state != HALTED) begin
                    retired_next = retired + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_decode_seq.sv
// tb_decode_seq: directed test of decode_seq with hand-computed expectations.
// A second instance with a 2-bit retire counter shares the stimulus to show
// the counter wrapping.
module tb_decode_seq;

    logic       clk;
    logic       clr;
    logic [7:0] ir;
    logic       ir_valid;

    logic       ir_ready;
    logic [1:0] rd_sel;
    logic [1:0] rs_sel;
    logic [3:0] imm;
    logic       imm_sel;
    logic       alu_op;
    logic       alu_en;
    logic [3:0] load;
    logic       halt;
    logic       illegal;
    logic [15:0] retired;

    logic       w_ir_ready;
    logic [1:0] w_rd_sel;
    logic [1:0] w_rs_sel;
    logic [3:0] w_imm;
    logic       w_imm_sel;
    logic       w_alu_op;
    logic       w_alu_en;
    logic [3:0] w_load;
    logic       w_halt;
    logic       w_illegal;
    logic [1:0] w_retired;

    int checks = 0;
    int errors = 0;

    decode_seq #(.IW(8), .NREG(4), .CW(16)) dut (
        .clk(clk), .clr(clr), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .rd_sel(rd_sel), .rs_sel(rs_sel), .imm(imm),
        .imm_sel(imm_sel), .alu_op(alu_op), .alu_en(alu_en), .load(load),
        .halt(halt), .illegal(illegal), .retired(retired)
    );

    decode_seq #(.IW(8), .NREG(4), .CW(2)) dut_wrap (
        .clk(clk), .clr(clr), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(w_ir_ready), .rd_sel(w_rd_sel), .rs_sel(w_rs_sel), .imm(w_imm),
        .imm_sel(w_imm_sel), .alu_op(w_alu_op), .alu_en(w_alu_en), .load(w_load),
        .halt(w_halt), .illegal(w_illegal), .retired(w_retired)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [7:0] word, input logic clear);
        ir_valid = valid;
        ir       = word;
        clr      = clear;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; each step begins 1 ns after a rising edge.
    initial begin
        apply_stimulus(1'b0, 8'h00, 1'b1);
        next_cycle();
        check_output("rst_ready_in_clr", 32'(ir_ready), 32'd0);
        check_output("rst_retired", 32'(retired), 32'd0);
        check_output("rst_halt", 32'(halt), 32'd0);
        check_output("rst_load", 32'(load), 32'd0);
        check_output("rst_alu_en", 32'(alu_en), 32'd0);
        check_output("rst_illegal", 32'(illegal), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("rst_ready", 32'(ir_ready), 32'd1);

        // LDI r1,5
        apply_stimulus(1'b1, 8'h15, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 8'hAA, 1'b0);
        check_output("ldi_decode_ready", 32'(ir_ready), 32'd0);
        check_output("ldi_decode_load", 32'(load), 32'd0);
        next_cycle();
        check_output("ldi_load", 32'(load), 32'b0010);
        check_output("ldi_imm_sel", 32'(imm_sel), 32'd1);
        check_output("ldi_imm", 32'(imm), 32'h5);
        check_output("ldi_rd_sel", 32'(rd_sel), 32'd1);
        next_cycle();
        check_output("ldi_load_off", 32'(load), 32'd0);
        check_output("ldi_ready", 32'(ir_ready), 32'd1);
        check_output("ldi_retired", 32'(retired), 32'd1);

        // ADD r2,r1 accepted in the first ready cycle
        apply_stimulus(1'b1, 8'h64, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        next_cycle();
        check_output("add_alu_en", 32'(alu_en), 32'd1);
        check_output("add_alu_op", 32'(alu_op), 32'd0);
        check_output("add_rs_sel", 32'(rs_sel), 32'd1);
        check_output("add_rd_sel", 32'(rd_sel), 32'd2);
        check_output("add_exec_load", 32'(load), 32'd0);
        next_cycle();
        check_output("add_load", 32'(load), 32'b0100);
        check_output("add_imm_sel", 32'(imm_sel), 32'd0);
        check_output("add_alu_en_off", 32'(alu_en), 32'd0);
        next_cycle();
        check_output("add_ready", 32'(ir_ready), 32'd1);
        check_output("add_retired", 32'(retired), 32'd2);

        // SUB r0,r3 back-to-back
        apply_stimulus(1'b1, 8'h8C, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        next_cycle();
        check_output("sub_alu_en", 32'(alu_en), 32'd1);
        check_output("sub_alu_op", 32'(alu_op), 32'd1);
        check_output("sub_rs_sel", 32'(rs_sel), 32'd3);
        next_cycle();
        check_output("sub_load", 32'(load), 32'b0001);
        next_cycle();
        check_output("sub_ready", 32'(ir_ready), 32'd1);
        check_output("sub_retired", 32'(retired), 32'd3);
        check_output("sub_alu_op_held", 32'(alu_op), 32'd1);

        // Illegal opcode 0xC0
        apply_stimulus(1'b1, 8'hC0, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        next_cycle();
        check_output("ill_pulse", 32'(illegal), 32'd1);
        check_output("ill_load", 32'(load), 32'd0);
        next_cycle();
        check_output("ill_pulse_off", 32'(illegal), 32'd0);
        check_output("ill_ready", 32'(ir_ready), 32'd1);
        check_output("ill_retired", 32'(retired), 32'd3);

        // HALT, then keep offering LDI while halted
        apply_stimulus(1'b1, 8'hFF, 1'b0);
        next_cycle();
        apply_stimulus(1'b1, 8'h15, 1'b0);
        check_output("halt_decode", 32'(halt), 32'd0);
        next_cycle();
        check_output("halt_set", 32'(halt), 32'd1);
        check_output("halt_retired", 32'(retired), 32'd4);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            check_output("halt_held", 32'(halt), 32'd1);
            check_output("halt_no_load", 32'(load), 32'd0);
            check_output("halt_ready", 32'(ir_ready), 32'd0);
        end
        apply_stimulus(1'b0, 8'h15, 1'b1);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("unhalt_halt", 32'(halt), 32'd0);
        check_output("unhalt_retired", 32'(retired), 32'd0);
        check_output("unhalt_ready", 32'(ir_ready), 32'd1);

        // Reset during the DECODE cycle of an ADD
        apply_stimulus(1'b1, 8'h64, 1'b0);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b1);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("midrst_ready", 32'(ir_ready), 32'd1);
        check_output("midrst_alu_en", 32'(alu_en), 32'd0);
        check_output("midrst_load", 32'(load), 32'd0);
        next_cycle();
        check_output("midrst_alu_en2", 32'(alu_en), 32'd0);
        check_output("midrst_load2", 32'(load), 32'd0);
        check_output("midrst_ready2", 32'(ir_ready), 32'd1);
        check_output("midrst_retired", 32'(retired), 32'd0);

        // clr and ir_valid together: no acceptance
        apply_stimulus(1'b1, 8'h15, 1'b1);
        check_output("cont_ready", 32'(ir_ready), 32'd0);
        next_cycle();
        apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("cont_still_fetch", 32'(ir_ready), 32'd1);
        next_cycle();
        check_output("cont_no_load", 32'(load), 32'd0);
        check_output("cont_ready2", 32'(ir_ready), 32'd1);

        // Five LDIs: 16-bit counter reads 5, 2-bit counter wraps to 1
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 8'h15, 1'b0);
            next_cycle();
            apply_stimulus(1'b0, 8'h00, 1'b0);
            next_cycle();
            next_cycle();
        end
        check_output("wrap_ref_retired", 32'(retired), 32'd5);
        check_output("wrap_retired", 32'(w_retired), 32'd1);
        check_output("wrap_ready", 32'(w_ir_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
